surf5_wb_arbiter: RTL and testbench
===================================

Name: surf5_wb_arbiter

Overview:
Two-master Wishbone arbiter that shares the SURF5 control Wishbone bus between the primary host master (M0, PCI/TURF path) and the debug VIO bridge master (M1). Grants one master per tenure, using round-robin priority on ties. A tenure lasts as long as the granted master holds CYC, so that master's lock sequences are atomic. An optional watchdog terminates stalled slave accesses with ERR, so a dead slave cannot hang the debug bridge or the host.

Parameters:
DW, 32, data width
AW, 20, address width
TIMEOUT_CYCLES, 1023, strobed cycles without ACK/ERR/RTY before watchdog fires (only used with the watchdog macro)

Ports:
clk_i  in  1  bus clock; all logic on posedge
rst_i  in  1  reset, asynchronous, active-high
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  M0 cycle/strobe/write-enable
m0_adr_i  in  AW  M0 address
m0_dat_i  in  DW  M0 write data
m0_dat_o  out  DW  M0 read data
m0_ack_o, m0_err_o, m0_rty_o  out  1 each  M0 terminations
m1_*  same set as m0_*  M1 (debug bridge)
s_cyc_o, s_stb_o, s_we_o  out  1 each  shared-bus cycle/strobe/write-enable
s_adr_o  out  AW  shared-bus address
s_dat_o  out  DW  shared-bus write data
s_dat_i  in  DW  shared-bus read data
s_ack_i, s_err_i, s_rty_i  in  1 each  shared-bus terminations
grant_o  out  2  one-hot current grant: bit0 = M0, bit1 = M1; 00 = idle
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (async assert): state IDLE, grant_o = 00, all s_* and m*_ack/err/rty outputs = 0, last_grant = M1 (so M0 wins the first tie), timeout_o = 0, watchdog counter = 0.
- State IDLE: evaluated on a clock edge.
  - Only m0_cyc_i high → GNT0.
  - Only m1_cyc_i high → GNT1.
  - Both high → grant the master not equal to last_grant.
  - Grant is registered: s_cyc_o rises 1 cycle after the winning m*_cyc_i is sampled.
- States GNT0/GNT1:
  - s_cyc/stb/we/adr/dat driven combinationally from the granted master; s_stb_o = granted stb & cyc.
  - Granted master receives s_dat_i, s_ack_i, s_err_i, s_rty_i. The ungranted master sees ack/err/rty = 0 and dat_o = s_dat_i, don't care.
  - Tenure ends when the granted m*_cyc_i is low at a clock edge. Next state is IDLE, last_grant is updated, and s_cyc_o drops in that same cycle.
  - There is always at least one IDLE turnaround cycle between tenures, even when the other master is already waiting.
- Preemption: none. A master holding CYC through multiple STB cycles (locked read-modify-write) keeps the bus indefinitely.
- A request arriving during another tenure waits; its ack/err/rty stay 0 and its signals are not forwarded.
- CYC dropped by the requester before grant: request withdrawn, no side effects.
- Reset mid-tenure: outputs return to reset values immediately (asynchronous); the slave sees CYC drop.

Optional Feature:
Macro SURF5_WB_ARB_WATCHDOG_EN.
- Defined, counter behaviour:
  - Counter increments every cycle while s_cyc_o & s_stb_o and no s_ack_i/s_err_i/s_rty_i.
  - Counter clears on any termination, on a tenure change, or in IDLE.
- Defined, on reaching TIMEOUT_CYCLES:
  - Granted master gets m*_err_o = 1 for exactly one cycle and timeout_o pulses.
  - s_stb_o is masked low until that master deasserts stb for one edge.
  - A late slave ACK arriving while masked is dropped, never forwarded.
- Not defined: no counter logic, timeout_o tied 0, stalled accesses wait forever.

Test Plan:
- Tie at first arbitration: M0 and M1 both assert cyc/stb on the cycle after reset → M0 granted (grant_o = 01); after M0 drops cyc and one IDLE cycle, M1 granted (grant_o = 10).
- Round-robin fairness: both masters continuously request single-beat reads with slave ack after 2 cycles → grants alternate 01, 00, 10, 00, 01 … and neither master is granted twice in a row.
- Lock hold: M1 holds cyc across a read then a write at adr 0x00010 while M0 requests throughout → M0 sees no ack and s_adr_o never shows M0's address until M1 drops cyc.
- Data routing: M0 reads adr 0xABCDE and the slave returns 0xDEADBEEF with ack → m0_dat_o = 0xDEADBEEF, m0_ack_o = 1 for one cycle, m1_ack_o = 0.
- Watchdog (macro on, TIMEOUT_CYCLES = 16): M1 strobes and the slave never acks → m1_err_o and timeout_o pulse after 16 stalled cycles, then s_stb_o = 0; with the macro off, stb stays high for at least 1000 cycles.
- Async reset mid-tenure: rst_i asserted between edges during a GNT0 read → s_cyc_o and grant_o go 0 before the next edge; after release, M0 wins a tie again.

Source files
------------

// File: rtl/surf5_wb_arbiter.sv
// ---------------------------------------------------------------------------
// surf5_wb_arbiter
//
// Two-master Wishbone arbiter for the SURF5 control bus. M0 is the host
// (PCI/TURF) master, M1 is the debug VIO bridge. One master owns the shared
// bus per tenure. A tenure lasts while the granted master holds CYC, so its
// locked sequences stay atomic. Simultaneous requests from IDLE are resolved
// round-robin against the previous owner. Every tenure is followed by at
// least one IDLE turnaround cycle.
//
// Optional watchdog: define SURF5_WB_ARB_WATCHDOG_EN to terminate strobed
// accesses that see no ACK/ERR/RTY within TIMEOUT_CYCLES stalled cycles.
// The owning master then gets a single-cycle ERR. Without the macro,
// timeout_o is tied low and a stalled access waits forever.
//
// State table:
//   IDLE | no owner, arbitrate on the next edge
//   GNT0 | M0 owns the shared bus
//   GNT1 | M1 owns the shared bus
//
// Ports:
//   clk_i, rst_i                   clock, async active-high reset
//   m0_* / m1_*                    master-side Wishbone (cyc, stb, we, adr,
//                                  dat in; dat, ack, err, rty out)
//   s_*                            shared slave-side Wishbone
//   grant_o                        one-hot owner (bit0 = M0, bit1 = M1)
//   timeout_o                      one-cycle pulse when the watchdog fires
// ---------------------------------------------------------------------------
module surf5_wb_arbiter #(
    parameter int DW             = 32,
    parameter int AW             = 20,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic          m0_rty_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          m1_rty_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    input  logic          s_rty_i,

    output logic [1:0]    grant_o,
    output logic          timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    // 0 = M0 owned the last tenure, 1 = M1. Resets to M1 so M0 wins the
    // first tie.
    logic   last_grant_q, last_grant_d;

    // Watchdog: wd_mask hides the stalled strobe from the slave and drops
    // late terminations. wd_fire_q is the registered one-cycle error pulse.
    logic   wd_mask;
    logic   wd_fire_q;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    state_d = last_grant_q ? GNT0 : GNT1;
                else if (m0_cyc_i)
                    state_d = GNT0;
                else if (m1_cyc_i)
                    state_d = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Bus steering. The forward path is combinational from the owner, so
    // s_cyc_o falls in the same cycle the owner drops CYC. Because IDLE
    // drives everything to zero, the async reset clears the slave side
    // immediately.
    // -----------------------------------------------------------------------
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_comb begin
        grant_o  = 2'b00;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        case (state_q)
            GNT0: begin
                grant_o  = 2'b01;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_cyc_i & m0_stb_i & ~wd_mask;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i & ~wd_mask;
                m0_err_o = (s_err_i & ~wd_mask) | wd_fire_q;
                m0_rty_o = s_rty_i & ~wd_mask;
            end
            GNT1: begin
                grant_o  = 2'b10;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_cyc_i & m1_stb_i & ~wd_mask;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i & ~wd_mask;
                m1_err_o = (s_err_i & ~wd_mask) | wd_fire_q;
                m1_rty_o = s_rty_i & ~wd_mask;
            end
            default: ;
        endcase
    end

    assign timeout_o = wd_fire_q;

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
`ifdef SURF5_WB_ARB_WATCHDOG_EN
    // The counter only ever holds 0..TIMEOUT_CYCLES-1. The fire decision is
    // taken on the edge that would complete the last stalled cycle.
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_cnt_q;
    logic            wd_mask_q;
    logic            gnt_stb;
    logic            s_term;
    logic            wd_stall;

    assign wd_mask  = wd_mask_q;
    assign s_term   = s_ack_i | s_err_i | s_rty_i;
    assign gnt_stb  = (state_q == GNT0) ? m0_stb_i :
                      (state_q == GNT1) ? m1_stb_i : 1'b0;
    assign wd_stall = s_cyc_o & s_stb_o & ~s_term;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt_q  <= '0;
            wd_mask_q <= 1'b0;
            wd_fire_q <= 1'b0;
        end else begin
            wd_fire_q <= 1'b0;
            if (state_q == IDLE || state_d != state_q) begin
                wd_cnt_q  <= '0;
                wd_mask_q <= 1'b0;
            end else if (wd_mask_q) begin
                // The stalled strobe must be withdrawn for one edge before
                // the owner may strobe the slave again.
                wd_cnt_q <= '0;
                if (!gnt_stb)
                    wd_mask_q <= 1'b0;
            end else if (s_term) begin
                wd_cnt_q <= '0;
            end else if (wd_stall) begin
                if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    wd_cnt_q  <= '0;
                    wd_mask_q <= 1'b1;
                    wd_fire_q <= 1'b1;
                end else begin
                    wd_cnt_q <= wd_cnt_q + 1'b1;
                end
            end
        end
    end
`else
    logic wd_unused;

    assign wd_mask   = 1'b0;
    assign wd_fire_q = 1'b0;
    assign wd_unused = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_surf5_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_surf5_wb_arbiter
//
// Directed bench for surf5_wb_arbiter. Each scenario task drives the masters
// and a hand-played slave, then compares outputs against hand-computed
// values. Inputs are driven 1 ns after the rising edge. Outputs are
// compared 1 ns after that.
// ---------------------------------------------------------------------------
module tb_surf5_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 20;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;

    logic          m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_adr = '0;
    logic [DW-1:0] m0_wdat = '0;
    logic [DW-1:0] m0_rdat;
    logic          m0_ack, m0_err, m0_rty;

    logic          m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_adr = '0;
    logic [DW-1:0] m1_wdat = '0;
    logic [DW-1:0] m1_rdat;
    logic          m1_ack, m1_err, m1_rty;

    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat;
    logic [DW-1:0] s_rdat = '0;
    logic          s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

    logic [1:0]    grant;
    logic          timeout;

    int total = 0;
    int bad   = 0;

    surf5_wb_arbiter #(
        .DW             (DW),
        .AW             (AW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .m0_cyc_i  (m0_cyc),
        .m0_stb_i  (m0_stb),
        .m0_we_i   (m0_we),
        .m0_adr_i  (m0_adr),
        .m0_dat_i  (m0_wdat),
        .m0_dat_o  (m0_rdat),
        .m0_ack_o  (m0_ack),
        .m0_err_o  (m0_err),
        .m0_rty_o  (m0_rty),
        .m1_cyc_i  (m1_cyc),
        .m1_stb_i  (m1_stb),
        .m1_we_i   (m1_we),
        .m1_adr_i  (m1_adr),
        .m1_dat_i  (m1_wdat),
        .m1_dat_o  (m1_rdat),
        .m1_ack_o  (m1_ack),
        .m1_err_o  (m1_err),
        .m1_rty_o  (m1_rty),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_adr_o   (s_adr),
        .s_dat_o   (s_wdat),
        .s_dat_i   (s_rdat),
        .s_ack_i   (s_ack),
        .s_err_i   (s_err),
        .s_rty_i   (s_rty),
        .grant_o   (grant),
        .timeout_o (timeout)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #300000;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1, "bench time limit");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
        total++;
        if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin bad++; $display("FAIL reset_s_cyc_stb: got %b%b want 00", s_cyc, s_stb); end
        total++;
        if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        total++;
        if ({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty} !== 6'b0) begin
            bad++; $display("FAIL reset_terms: got %b want 000000", {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty});
        end
        total++;
        @(negedge clk_i);
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_tie();
        m0_cyc = 1; m0_stb = 1; m0_adr = 20'h11111;
        m1_cyc = 1; m1_stb = 1; m1_adr = 20'h22222;
        step();
        if (grant !== 2'b01) begin bad++; $display("FAIL tie_first_grant: got %b want 01", grant); end
        total++;
        if (s_adr !== 20'h11111) begin bad++; $display("FAIL tie_s_adr_m0: got %h want 11111", s_adr); end
        total++;
        s_ack = 1; #1;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin bad++; $display("FAIL tie_ack_route: got m0=%b m1=%b want 1 0", m0_ack, m1_ack); end
        total++;
        step();
        s_ack = 0; m0_cyc = 0; m0_stb = 0; #1;
        if (s_cyc !== 1'b0) begin bad++; $display("FAIL tie_cyc_drop: got %b want 0", s_cyc); end
        total++;
        step();
        if (grant !== 2'b00) begin bad++; $display("FAIL tie_turnaround: got %b want 00", grant); end
        total++;
        step();
        if (grant !== 2'b10) begin bad++; $display("FAIL tie_second_grant: got %b want 10", grant); end
        total++;
        if (s_adr !== 20'h22222) begin bad++; $display("FAIL tie_s_adr_m1: got %h want 22222", s_adr); end
        total++;
        s_ack = 1; step();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        step(); step();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 20'h00100;
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 20'h00200;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            step();
            if (grant !== exp_g) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, exp_g); end
            total++;
            step();
            s_ack = 1; #1;
            if ({m1_ack, m0_ack} !== exp_g) begin bad++; $display("FAIL rr_ack[%0d]: got %b want %b", i, {m1_ack, m0_ack}, exp_g); end
            total++;
            step();
            s_ack = 0;
            if (exp_g == 2'b01) begin m0_cyc = 0; m0_stb = 0; end
            else begin m1_cyc = 0; m1_stb = 0; end
            #1;
            if (s_cyc !== 1'b0) begin bad++; $display("FAIL rr_cyc_drop[%0d]: got %b want 0", i, s_cyc); end
            total++;
            step();
            if (grant !== 2'b00) begin bad++; $display("FAIL rr_idle[%0d]: got %b want 00", i, grant); end
            total++;
            if (i < 3) begin
                if (exp_g == 2'b01) begin m0_cyc = 1; m0_stb = 1; end
                else begin m1_cyc = 1; m1_stb = 1; end
            end
        end
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        step();
    endtask

    task automatic test_lock();
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 20'h00010;
        step();
        if (grant !== 2'b10) begin bad++; $display("FAIL lock_grant_m1: got %b want 10", grant); end
        total++;
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 20'h55555;
        step();
        s_ack = 1; #1;
        if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin bad++; $display("FAIL lock_read_ack: got m1=%b m0=%b want 1 0", m1_ack, m0_ack); end
        total++;
        if (s_adr !== 20'h00010) begin bad++; $display("FAIL lock_read_adr: got %h want 00010", s_adr); end
        total++;
        step();
        s_ack = 0; m1_stb = 0; #1;
        if (s_stb !== 1'b0 || s_cyc !== 1'b1 || s_adr !== 20'h00010) begin
            bad++; $display("FAIL lock_gap: got stb=%b cyc=%b adr=%h want 0 1 00010", s_stb, s_cyc, s_adr);
        end
        total++;
        step();
        m1_stb = 1; m1_we = 1; m1_wdat = 32'h12345678; #1;
        if (s_we !== 1'b1 || s_wdat !== 32'h12345678) begin bad++; $display("FAIL lock_write_fwd: got we=%b dat=%h want 1 12345678", s_we, s_wdat); end
        total++;
        step();
        s_ack = 1; #1;
        if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || s_adr !== 20'h00010) begin
            bad++; $display("FAIL lock_write_ack: got m1=%b m0=%b adr=%h want 1 0 00010", m1_ack, m0_ack, s_adr);
        end
        total++;
        step();
        s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0; #1;
        if (s_cyc !== 1'b0 || grant !== 2'b10) begin bad++; $display("FAIL lock_release: got cyc=%b grant=%b want 0 10", s_cyc, grant); end
        total++;
        step();
        if (grant !== 2'b00) begin bad++; $display("FAIL lock_turnaround: got %b want 00", grant); end
        total++;
        step();
        if (grant !== 2'b01 || s_adr !== 20'h55555) begin bad++; $display("FAIL lock_m0_after: got grant=%b adr=%h want 01 55555", grant, s_adr); end
        total++;
        s_ack = 1; step();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        step(); step();
    endtask

    task automatic test_data_routing();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 20'hABCDE;
        step();
        if (s_adr !== 20'hABCDE || s_we !== 1'b0) begin bad++; $display("FAIL data_adr: got adr=%h we=%b want abcde 0", s_adr, s_we); end
        total++;
        s_rdat = 32'hDEADBEEF; s_ack = 1; #1;
        if (m0_rdat !== 32'hDEADBEEF) begin bad++; $display("FAIL data_m0_rdat: got %h want deadbeef", m0_rdat); end
        total++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin bad++; $display("FAIL data_ack: got m0=%b m1=%b want 1 0", m0_ack, m1_ack); end
        total++;
        step();
        s_ack = 0; #1;
        if (m0_ack !== 1'b0) begin bad++; $display("FAIL data_ack_one_cycle: got %b want 0", m0_ack); end
        total++;
        s_rty = 1; #1;
        if (m0_rty !== 1'b1 || m1_rty !== 1'b0) begin bad++; $display("FAIL data_rty: got m0=%b m1=%b want 1 0", m0_rty, m1_rty); end
        total++;
        s_rty = 0; s_err = 1; #1;
        if (m0_err !== 1'b1 || m1_err !== 1'b0) begin bad++; $display("FAIL data_err: got m0=%b m1=%b want 1 0", m0_err, m1_err); end
        total++;
        step();
        s_err = 0; m0_cyc = 0; m0_stb = 0;
        step(); step();
    endtask

    task automatic test_async_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 20'h00ABC;
        step();
        if (grant !== 2'b01 || s_cyc !== 1'b1) begin bad++; $display("FAIL areset_pre: got grant=%b cyc=%b want 01 1", grant, s_cyc); end
        total++;
        #2; rst_i = 1; #1;
        if (s_cyc !== 1'b0 || grant !== 2'b00 || s_stb !== 1'b0) begin
            bad++; $display("FAIL areset_immediate: got cyc=%b stb=%b grant=%b want 0 0 00", s_cyc, s_stb, grant);
        end
        total++;
        m1_cyc = 1; m1_stb = 1; m1_adr = 20'h00DEF;
        @(negedge clk_i);
        rst_i = 0;
        step();
        if (grant !== 2'b01) begin bad++; $display("FAIL areset_tie_m0: got %b want 01", grant); end
        total++;
        m0_cyc = 0; m0_stb = 0;
        step(); step();
        if (grant !== 2'b10) begin bad++; $display("FAIL areset_then_m1: got %b want 10", grant); end
        total++;
        m1_cyc = 0; m1_stb = 0;
        step(); step();
    endtask

    task automatic test_watchdog();
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 20'h0F00F;
        step();
        if (grant !== 2'b10) begin bad++; $display("FAIL wd_grant: got %b want 10", grant); end
        total++;
`ifdef SURF5_WB_ARB_WATCHDOG_EN
        for (int i = 1; i <= 15; i++) begin
            step();
            if (timeout !== 1'b0 || m1_err !== 1'b0 || s_stb !== 1'b1) begin
                bad++; $display("FAIL wd_pre[%0d]: got to=%b err=%b stb=%b want 0 0 1", i, timeout, m1_err, s_stb);
            end
            total++;
        end
        step();
        if (timeout !== 1'b1 || m1_err !== 1'b1 || m0_err !== 1'b0) begin
            bad++; $display("FAIL wd_fire: got to=%b m1_err=%b m0_err=%b want 1 1 0", timeout, m1_err, m0_err);
        end
        total++;
        if (s_stb !== 1'b0) begin bad++; $display("FAIL wd_mask: got stb=%b want 0", s_stb); end
        total++;
        s_ack = 1; #1;
        if (m1_ack !== 1'b0) begin bad++; $display("FAIL wd_late_ack: got %b want 0", m1_ack); end
        total++;
        step();
        if (timeout !== 1'b0 || m1_err !== 1'b0 || s_stb !== 1'b0) begin
            bad++; $display("FAIL wd_after: got to=%b err=%b stb=%b want 0 0 0", timeout, m1_err, s_stb);
        end
        total++;
        s_ack = 0; m1_stb = 0;
        step();
        m1_stb = 1; #1;
        if (s_stb !== 1'b1) begin bad++; $display("FAIL wd_unmask: got stb=%b want 1", s_stb); end
        total++;
`else
        for (int i = 0; i < 1000; i++) begin
            step();
            if (s_stb !== 1'b1 || timeout !== 1'b0 || m1_err !== 1'b0) begin
                bad++; $display("FAIL wd_off_hold[%0d]: got stb=%b to=%b err=%b want 1 0 0", i, s_stb, timeout, m1_err);
            end
            total++;
        end
`endif
        s_ack = 1; step();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_round_robin();
        test_lock();
        test_data_routing();
        test_async_reset();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
